// File: rtl/microondas_timer_pwr.sv
// rtl/microondas_timer_pwr.sv - microwave cook controller: BCD mm:ss entry, 1 Hz countdown, duty-cycled magnetron
// One FSM owns time digits, prescaler and power window; mag_on gates on the live door level.
module microondas_timer_pwr #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int MAX_MIN    = 9,
  parameter int PWR_PERIOD = 10,
  parameter int QUICK_SEC  = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start_p,
  input  logic       stop_p,
  input  logic       clear_p,
  input  logic       door_closed,
  input  logic [3:0] power_level,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] mins,
  output logic       mag_on,
  output logic       done,
  output logic [1:0] state
);

  localparam int PW = $clog2(CLK_FREQ);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_FREQ - 1);
  localparam logic [3:0]    PWR_LAST = 4'(PWR_PERIOD - 1);
  localparam logic [3:0]    MAX_M    = 4'(MAX_MIN);
  localparam logic [3:0]    QUICK_T  = 4'(QUICK_SEC / 10);
  localparam logic [3:0]    QUICK_O  = 4'(QUICK_SEC % 10);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SET   = 2'b01,
    COOK  = 2'b10,
    PAUSE = 2'b11
  } state_t;

  state_t        st;
  logic [PW-1:0] prescaler;
  logic [3:0]    pwr_cnt;
  logic [3:0]    pwr_lat;

  logic time_zero;
  logic last_sec;
  logic tick;
  logic key_ok;
  logic start_ok;

  assign time_zero = (mins == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);
  assign last_sec  = (mins == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd1);
  assign tick      = (prescaler == PRE_LAST);

  // A shifted-in digit must leave a legal mm:ss, so the digits moving up are screened.
  assign key_ok = key_valid && (key_digit <= 4'd9) && (sec_ones <= 4'd5) &&
                  (sec_tens <= MAX_M) && ((st == IDLE) || (st == SET));

  assign start_ok = door_closed &&
                    ((st == IDLE) || (st == PAUSE) || ((st == SET) && !time_zero));

  assign state  = st;
  assign mag_on = (st == COOK) && door_closed && (pwr_cnt < pwr_lat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      mins      <= 4'd0;
      sec_tens  <= 4'd0;
      sec_ones  <= 4'd0;
      prescaler <= '0;
      pwr_cnt   <= 4'd0;
      pwr_lat   <= 4'd0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear_p) begin
        st        <= IDLE;
        mins      <= 4'd0;
        sec_tens  <= 4'd0;
        sec_ones  <= 4'd0;
        prescaler <= '0;
        pwr_cnt   <= 4'd0;
      end else if (stop_p) begin
        case (st)
          COOK: st <= PAUSE;
          PAUSE, SET: begin
            st       <= IDLE;
            mins     <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
          end
          default: st <= st;
        endcase
      end else if ((st == COOK) && !door_closed) begin
        st <= PAUSE;
      end else if (start_p && (st != COOK)) begin
        if (start_ok) begin
          st      <= COOK;
          pwr_lat <= power_level;
          // Resuming from PAUSE keeps the partial second and the power window position.
          if (st != PAUSE) begin
            prescaler <= '0;
            pwr_cnt   <= 4'd0;
          end
          if (st == IDLE) begin
            mins     <= 4'd0;
            sec_tens <= QUICK_T;
            sec_ones <= QUICK_O;
          end
        end
      end else if (key_ok) begin
        st       <= SET;
        mins     <= sec_tens;
        sec_tens <= sec_ones;
        sec_ones <= key_digit;
      end else if (st == COOK) begin
        if (tick) begin
          prescaler <= '0;
          pwr_cnt   <= (pwr_cnt >= PWR_LAST) ? 4'd0 : pwr_cnt + 4'd1;
          if (sec_ones != 4'd0) begin
            sec_ones <= sec_ones - 4'd1;
          end else begin
            sec_ones <= 4'd9;
            if (sec_tens != 4'd0) begin
              sec_tens <= sec_tens - 4'd1;
            end else begin
              sec_tens <= 4'd5;
              mins     <= mins - 4'd1;
            end
          end
          if (last_sec) begin
            st   <= IDLE;
            done <= 1'b1;
          end
        end else begin
          prescaler <= prescaler + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_microondas_timer_pwr.sv
// tb/tb_microondas_timer_pwr.sv - directed and random checks of microondas_timer_pwr against a seconds-based model
module tb_microondas_timer_pwr;

  localparam int CF = 4;
  localparam int PP = 4;
  localparam int QS = 30;
  localparam int MM = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start_p = 1'b0;
  logic       stop_p = 1'b0;
  logic       clear_p = 1'b0;
  logic       door_closed = 1'b1;
  logic [3:0] power_level = 4'd0;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] mins;
  logic       mag_on;
  logic       done;
  logic [1:0] state;

  microondas_timer_pwr #(
    .CLK_FREQ(CF), .MAX_MIN(MM), .PWR_PERIOD(PP), .QUICK_SEC(QS)
  ) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_digit(key_digit),
    .start_p(start_p), .stop_p(stop_p), .clear_p(clear_p),
    .door_closed(door_closed), .power_level(power_level),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .mins(mins),
    .mag_on(mag_on), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: time kept as total seconds, digits derived arithmetically.
  localparam int S_IDLE = 0, S_SET = 1, S_COOK = 2, S_PAUSE = 3;
  int m_st, m_secs, m_pre, m_pc, m_lat, m_done;
  int m_dm, m_dt, m_do;

  function automatic void set_secs(input int s);
    m_secs = s;
    m_dm = s / 60;
    m_dt = (s % 60) / 10;
    m_do = s % 10;
  endfunction

  function automatic void model_reset();
    m_st = S_IDLE; m_pre = 0; m_pc = 0; m_lat = 0; m_done = 0;
    set_secs(0);
  endfunction

  function automatic void model_step();
    m_done = 0;
    if (clear_p) begin
      m_st = S_IDLE; set_secs(0); m_pre = 0; m_pc = 0;
    end else if (stop_p) begin
      if (m_st == S_COOK) m_st = S_PAUSE;
      else if (m_st != S_IDLE) begin m_st = S_IDLE; set_secs(0); end
    end else if (m_st == S_COOK && !door_closed) begin
      m_st = S_PAUSE;
    end else if (start_p && m_st != S_COOK) begin
      if (door_closed && (m_st != S_SET || m_secs != 0)) begin
        if (m_st != S_PAUSE) begin m_pre = 0; m_pc = 0; end
        if (m_st == S_IDLE) set_secs(QS);
        m_lat = int'(power_level);
        m_st = S_COOK;
      end
    end else if (key_valid && (m_st == S_IDLE || m_st == S_SET)) begin
      if (key_digit <= 9 && m_do <= 5 && m_dt <= MM) begin
        m_dm = m_dt; m_dt = m_do; m_do = int'(key_digit);
        m_secs = m_dm * 60 + m_dt * 10 + m_do;
        m_st = S_SET;
      end
    end else if (m_st == S_COOK) begin
      m_pre = m_pre + 1;
      if (m_pre == CF) begin
        m_pre = 0;
        m_pc = (m_pc + 1) % PP;
        set_secs(m_secs - 1);
        if (m_secs == 0) begin m_st = S_IDLE; m_done = 1; end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state", 16'(state), 16'(m_st));
    chk("mins", 16'(mins), 16'(m_dm));
    chk("sec_tens", 16'(sec_tens), 16'(m_dt));
    chk("sec_ones", 16'(sec_ones), 16'(m_do));
    chk("done", 16'(done), 16'(m_done));
    chk("mag_on", 16'(mag_on), 16'((m_st == S_COOK) && door_closed && (m_pc < m_lat)));
  endtask

  task automatic cyc(input logic c, input logic s, input logic g, input logic kv,
                     input logic [3:0] kd, input logic dr, input logic [3:0] pl);
    clear_p = c; stop_p = s; start_p = g; key_valid = kv; key_digit = kd;
    door_closed = dr; power_level = pl;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 4'd0, door_closed, power_level);
  endtask

  task automatic key(input logic [3:0] d);
    cyc(0, 0, 0, 1, d, 1'b1, power_level);
  endtask

  task automatic start(input logic [3:0] pl);
    cyc(0, 0, 1, 0, 4'd0, 1'b1, pl);
  endtask

  task automatic clear();
    cyc(1, 0, 0, 0, 4'd0, 1'b1, power_level);
  endtask

  int mag_cnt;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_mag", 16'(mag_on), 16'd0);
    rst = 1'b0;

    // 1:30 entry and first tick
    key(4'd1); key(4'd3); key(4'd0);
    start(4'd4);
    chk("t130_mins", 16'(mins), 16'd1);
    chk("t130_tens", 16'(sec_tens), 16'd3);
    chk("t130_state", 16'(state), 16'd2);
    idle_n(4);
    chk("t129_ones", 16'(sec_ones), 16'd9);
    chk("t129_tens", 16'(sec_tens), 16'd2);
    chk("t129_mag", 16'(mag_on), 16'd1);

    // double borrow 1:00 -> 0:59
    clear();
    key(4'd1); key(4'd0); key(4'd0);
    start(4'd4);
    idle_n(4);
    chk("t059_mins", 16'(mins), 16'd0);
    chk("t059_tens", 16'(sec_tens), 16'd5);
    chk("t059_ones", 16'(sec_ones), 16'd9);

    // 0:01 -> 0:00 with one-cycle done
    clear();
    key(4'd1);
    start(4'd4);
    idle_n(4);
    chk("done_pulse", 16'(done), 16'd1);
    chk("done_idle", 16'(state), 16'd0);
    idle_n(1);
    chk("done_drop", 16'(done), 16'd0);

    // power level 1 over 8 ticks
    clear();
    key(4'd1); key(4'd0); key(4'd0);
    start(4'd1);
    mag_cnt = int'(mag_on);
    for (int i = 0; i < 8 * CF - 1; i++) begin
      idle_n(1);
      mag_cnt += int'(mag_on);
    end
    chk("duty_1of4", 16'(mag_cnt), 16'd8);

    // door open mid-cook: mag_on drops combinationally, then PAUSE, then resume
    clear();
    key(4'd2); key(4'd0);
    start(4'd15);
    idle_n(5);
    door_closed = 1'b0;
    #1;
    chk("door_mag", 16'(mag_on), 16'd0);
    chk("door_still_cook", 16'(state), 16'd2);
    cyc(0, 0, 0, 0, 4'd0, 1'b0, 4'd15);
    chk("door_pause", 16'(state), 16'd3);
    idle_n(6);
    chk("pause_hold_ones", 16'(sec_ones), 16'd9);
    cyc(0, 0, 1, 0, 4'd0, 1'b0, 4'd15);
    chk("start_door_open", 16'(state), 16'd3);
    start(4'd15);
    idle_n(10);

    // quick-start and key screening
    clear();
    start(4'd3);
    chk("quick_tens", 16'(sec_tens), 16'd3);
    chk("quick_state", 16'(state), 16'd2);
    cyc(0, 1, 0, 0, 4'd0, 1'b1, 4'd3);
    cyc(0, 1, 0, 0, 4'd0, 1'b1, 4'd3);
    key(4'd7); key(4'd7); key(4'd7); key(4'd12);
    chk("key777_tens", 16'(sec_tens), 16'd0);
    chk("key777_ones", 16'(sec_ones), 16'd7);

    // clear beats stop and start in COOK
    key(4'd0);
    start(4'd2);
    idle_n(3);
    cyc(1, 1, 1, 0, 4'd0, 1'b1, 4'd2);
    chk("clr_state", 16'(state), 16'd0);
    chk("clr_ones", 16'(sec_ones), 16'd0);

    // async reset mid-cook
    start(4'd9);
    idle_n(3);
    rst = 1'b1;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // random mix against the model
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 79) == 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
          4'($urandom_range(0, 15)), $urandom_range(0, 24) != 0,
          4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
